// File: rtl/traffic_pkg.sv
// Shared state codes, lamp encodings and widths for the traffic light controller.
package traffic_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned LAMP_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_NS_G  = 3'd0,
        ST_NS_Y  = 3'd1,
        ST_RED_A = 3'd2,
        ST_EW_G  = 3'd3,
        ST_EW_Y  = 3'd4,
        ST_RED_B = 3'd5,
        ST_WALK  = 3'd6,
        ST_BAD   = 3'd7
    } state_e;

    // Lamp bits are {R,Y,G}, exactly one lit.
    typedef logic [LAMP_W-1:0] lamp_t;

    localparam lamp_t LAMP_RED    = 3'b100;
    localparam lamp_t LAMP_YELLOW = 3'b010;
    localparam lamp_t LAMP_GREEN  = 3'b001;

endpackage

// File: rtl/dff.sv
// Generic register with synchronous active-high reset to a parameterised value.
module dff #(
    parameter int unsigned                REGISTER_WIDTH = 1,
    parameter logic [REGISTER_WIDTH-1:0] RESET_VALUE    = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REGISTER_WIDTH-1:0] d,
    output logic [REGISTER_WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) q <= RESET_VALUE;
        else     q <= d;
    end

endmodule

// File: rtl/phase_timer.sv
// Tick-driven phase timer: expires on the tick where the count reaches dur-1.
module phase_timer #(
    parameter int unsigned TIMER_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   clear,
    input  logic [TIMER_WIDTH-1:0] dur,
    output logic                   expire
);

    logic [TIMER_WIDTH-1:0] timer_q;
    logic [TIMER_WIDTH-1:0] timer_d;

    assign expire = tick && (timer_q == (dur - TIMER_WIDTH'(1)));

    // Expiry always precedes wrap for legal durations, so no saturation is needed.
    always_comb begin
        timer_d = timer_q;
        if (clear || expire) timer_d = '0;
        else if (tick)       timer_d = timer_q + TIMER_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) timer_q <= '0;
        else     timer_q <= timer_d;
    end

endmodule

// File: rtl/traffic_light_fsm.sv
// Two-way intersection controller with pedestrian phase and emergency preempt.
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int unsigned TIMER_WIDTH  = 8,
    parameter int unsigned GREEN_TICKS  = 20,
    parameter int unsigned YELLOW_TICKS = 4,
    parameter int unsigned ALLRED_TICKS = 2,
    parameter int unsigned WALK_TICKS   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               ped_req,
    input  logic               emerg,
    output logic [LAMP_W-1:0]  ns_light,
    output logic [LAMP_W-1:0]  ew_light,
    output logic               walk,
    output logic [STATE_W-1:0] state
);

    localparam logic [TIMER_WIDTH-1:0] DUR_GREEN  = TIMER_WIDTH'(GREEN_TICKS);
    localparam logic [TIMER_WIDTH-1:0] DUR_YELLOW = TIMER_WIDTH'(YELLOW_TICKS);
    localparam logic [TIMER_WIDTH-1:0] DUR_ALLRED = TIMER_WIDTH'(ALLRED_TICKS);
    localparam logic [TIMER_WIDTH-1:0] DUR_WALK   = TIMER_WIDTH'(WALK_TICKS);

    logic [STATE_W-1:0]     state_raw;
    state_e                 state_q;
    state_e                 state_d;
    logic                   ped_pending_q;
    logic                   ped_pending_d;
    logic                   tmr_clear;
    logic                   expire;
    logic [TIMER_WIDTH-1:0] dur_c;

    dff #(
        .REGISTER_WIDTH (STATE_W),
        .RESET_VALUE    (ST_RED_B)
    ) u_state_reg (
        .clk (clk),
        .rst (rst),
        .d   (state_d),
        .q   (state_raw)
    );

    assign state_q = state_e'(state_raw);

    dff #(
        .REGISTER_WIDTH (1),
        .RESET_VALUE    (1'b0)
    ) u_pending_reg (
        .clk (clk),
        .rst (rst),
        .d   (ped_pending_d),
        .q   (ped_pending_q)
    );

    phase_timer #(
        .TIMER_WIDTH (TIMER_WIDTH)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .clear  (tmr_clear),
        .dur    (dur_c),
        .expire (expire)
    );

    // Duration of the phase currently being timed.
    always_comb begin
        dur_c = DUR_ALLRED;
        case (state_q)
            ST_NS_G, ST_EW_G: dur_c = DUR_GREEN;
            ST_NS_Y, ST_EW_Y: dur_c = DUR_YELLOW;
            ST_WALK:          dur_c = DUR_WALK;
            default:          dur_c = DUR_ALLRED;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        tmr_clear = 1'b0;
        case (state_q)
            ST_NS_G: begin
                if (emerg) begin
                    state_d   = ST_NS_Y;
                    tmr_clear = 1'b1;
                end else if (expire) begin
                    state_d = ST_NS_Y;
                end
            end
            ST_NS_Y: if (expire) state_d = ST_RED_A;
            ST_RED_A: begin
                if (emerg)       tmr_clear = 1'b1;
                else if (expire) state_d   = ST_EW_G;
            end
            ST_EW_G: begin
                if (emerg) begin
                    state_d   = ST_EW_Y;
                    tmr_clear = 1'b1;
                end else if (expire) begin
                    state_d = ST_EW_Y;
                end
            end
            ST_EW_Y: if (expire) state_d = ST_RED_B;
            ST_RED_B: begin
                if (emerg)       tmr_clear = 1'b1;
                else if (expire) state_d   = ped_pending_q ? ST_WALK : ST_NS_G;
            end
            ST_WALK: begin
                if (emerg) begin
                    state_d   = ST_RED_B;
                    tmr_clear = 1'b1;
                end else if (expire) begin
                    state_d = ST_NS_G;
                end
            end
            default: begin
                state_d   = ST_RED_B;
                tmr_clear = 1'b1;
            end
        endcase

        // A new request on the WALK-entry edge survives for the next cycle.
        ped_pending_d = ped_pending_q;
        if (state_d == ST_WALK && state_q != ST_WALK) ped_pending_d = 1'b0;
        if (ped_req)                                  ped_pending_d = 1'b1;
    end

    // Moore decode of the state register only.
    always_comb begin
        ns_light = LAMP_RED;
        ew_light = LAMP_RED;
        walk     = 1'b0;
        state    = state_raw;
        case (state_q)
            ST_NS_G: ns_light = LAMP_GREEN;
            ST_NS_Y: ns_light = LAMP_YELLOW;
            ST_EW_G: ew_light = LAMP_GREEN;
            ST_EW_Y: ew_light = LAMP_YELLOW;
            ST_WALK: walk     = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Self-checking bench for traffic_light_fsm with short phase durations.
module tb_traffic_light_fsm;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       ped_req;
    logic       emerg;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic [2:0] state;

    int tests  = 0;
    int failed = 0;

    logic [2:0] exp_q[$];

    typedef struct {
        logic       rst;
        logic       tick;
        logic       ped;
        logic       emerg;
        logic [2:0] st;
    } vec_t;

    vec_t vecs[$];

    traffic_light_fsm #(
        .TIMER_WIDTH  (8),
        .GREEN_TICKS  (4),
        .YELLOW_TICKS (2),
        .ALLRED_TICKS (1),
        .WALK_TICKS   (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .ped_req  (ped_req),
        .emerg    (emerg),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .walk     (walk),
        .state    (state)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] model_ns(input logic [2:0] s);
        case (s)
            3'd0:    return 3'b001;
            3'd1:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] model_ew(input logic [2:0] s);
        case (s)
            3'd3:    return 3'b001;
            3'd4:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Pop the oldest expectation and compare every output against it.
    task automatic check_out(input string tag);
        logic [2:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, "_state"}, 32'(state), 32'(e));
        chk({tag, "_ns"},    32'(ns_light), 32'(model_ns(e)));
        chk({tag, "_ew"},    32'(ew_light), 32'(model_ew(e)));
        chk({tag, "_walk"},  32'(walk), 32'(e == 3'd6));
        chk({tag, "_safe"},  32'(ns_light != 3'b100 && ew_light != 3'b100), 32'd0);
    endtask

    task automatic step(input logic r, input logic t, input logic p, input logic e,
                        input logic [2:0] st, input string tag);
        @(negedge clk);
        rst = r; tick = t; ped_req = p; emerg = e;
        exp_q.push_back(st);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    function automatic vec_t mk(input logic r, input logic p, input logic e, input logic [2:0] st);
        vec_t v;
        v.rst = r; v.tick = 1'b1; v.ped = p; v.emerg = e; v.st = st;
        return v;
    endfunction

    initial begin
        logic [2:0] run_seq[15];
        rst = 1'b1; tick = 1'b0; ped_req = 1'b0; emerg = 1'b0;

        // Reset with competing inputs, then one full free-running cycle.
        run_seq = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3,
                    3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd0};
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 3'd5));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 3'd5));
        foreach (run_seq[i]) vecs.push_back(mk(1'b0, 1'b0, 1'b0, run_seq[i]));
        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].rst, vecs[i].tick, vecs[i].ped, vecs[i].emerg, vecs[i].st,
                 $sformatf("vec%0d", i));
        chk("reset_pending", 32'(dut.ped_pending_q), 32'd0);

        // Pedestrian pulse during EW_G leads to a 3-cycle WALK after RED_B.
        step(0, 1, 0, 0, 3'd0, "ped0"); step(0, 1, 0, 0, 3'd0, "ped1");
        step(0, 1, 0, 0, 3'd0, "ped2"); step(0, 1, 0, 0, 3'd1, "ped3");
        step(0, 1, 0, 0, 3'd1, "ped4"); step(0, 1, 0, 0, 3'd2, "ped5");
        step(0, 1, 0, 0, 3'd3, "ped6"); step(0, 1, 1, 0, 3'd3, "ped7");
        chk("ped_latched", 32'(dut.ped_pending_q), 32'd1);
        step(0, 1, 0, 0, 3'd3, "ped8"); step(0, 1, 0, 0, 3'd3, "ped9");
        step(0, 1, 0, 0, 3'd4, "ped10"); step(0, 1, 0, 0, 3'd4, "ped11");
        step(0, 1, 0, 0, 3'd5, "ped12"); step(0, 1, 0, 0, 3'd6, "ped13");
        chk("ped_cleared", 32'(dut.ped_pending_q), 32'd0);
        step(0, 1, 0, 0, 3'd6, "ped14"); step(0, 1, 0, 0, 3'd6, "ped15");
        step(0, 1, 0, 0, 3'd0, "ped16");

        // Emergency cuts green, lets yellow finish and holds all-red.
        step(0, 1, 0, 0, 3'd0, "em0"); step(0, 1, 0, 1, 3'd1, "em1");
        step(0, 1, 0, 1, 3'd1, "em2"); step(0, 1, 0, 1, 3'd2, "em3");
        step(0, 1, 0, 1, 3'd2, "em4"); step(0, 1, 0, 1, 3'd2, "em5");
        chk("em_timer_held", 32'(dut.u_timer.timer_q), 32'd0);
        step(0, 1, 0, 0, 3'd3, "em6"); step(0, 1, 0, 1, 3'd4, "em7");
        step(0, 1, 0, 1, 3'd4, "em8"); step(0, 1, 0, 1, 3'd5, "em9");
        step(0, 1, 0, 1, 3'd5, "em10"); step(0, 1, 0, 0, 3'd0, "em11");

        // Sparse tick: NS_G spans 12 cycles and the timer holds between ticks.
        for (int i = 0; i < 12; i++) begin
            step(0, (i % 3) == 2, 0, 0, (i == 11) ? 3'd1 : 3'd0, $sformatf("tk%0d", i));
            chk($sformatf("tk%0d_timer", i), 32'(dut.u_timer.timer_q),
                (i == 11) ? 32'd0 : 32'((i + 1) / 3));
        end

        // Reset mid EW_Y with a request pending discards the request.
        step(0, 1, 0, 0, 3'd1, "rs0"); step(0, 1, 0, 0, 3'd2, "rs1");
        step(0, 1, 1, 0, 3'd3, "rs2"); step(0, 1, 0, 0, 3'd3, "rs3");
        step(0, 1, 0, 0, 3'd3, "rs4"); step(0, 1, 0, 0, 3'd3, "rs5");
        step(0, 1, 0, 0, 3'd4, "rs6");
        chk("rs_pending_before", 32'(dut.ped_pending_q), 32'd1);
        step(1, 1, 0, 0, 3'd5, "rs7");
        chk("rs_timer", 32'(dut.u_timer.timer_q), 32'd0);
        chk("rs_pending", 32'(dut.ped_pending_q), 32'd0);
        step(0, 1, 0, 0, 3'd0, "rs8");

        // Illegal code 7 recovers to RED_B on the next edge.
        @(negedge clk);
        rst = 1'b0; tick = 1'b1; ped_req = 1'b0; emerg = 1'b0;
        force dut.state_d = ST_BAD;
        exp_q.push_back(3'd7);
        @(posedge clk);
        #1;
        release dut.state_d;
        emerg = 1'b1;
        #1;
        emerg = 1'b0;
        check_out("bad7");
        step(0, 1, 0, 0, 3'd5, "bad8");
        step(0, 1, 0, 0, 3'd0, "bad9");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/traffic_light_fsm.md
TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

Interface
REQ-001 SHALL have parameters: TIMER_WIDTH, default 8, phase timer width; GREEN_TICKS, default 20, green duration; YELLOW_TICKS, default 4, yellow duration; ALLRED_TICKS, default 2, all-red duration; WALK_TICKS, default 10, walk duration.
REQ-002 SHALL accept only durations in 1..2^TIMER_WIDTH-1; other values are unsupported.
REQ-003 clk  input  1  sole clock, all state updates on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 tick  input  1  one-cycle time-base enable; the timer advances only when tick=1.
REQ-006 ped_req  input  1  pedestrian request pulse or level, latched internally.
REQ-007 emerg  input  1  emergency preempt level.
REQ-008 ns_light  output  3  north-south lamp, {R,Y,G} one-hot.
REQ-009 ew_light  output  3  east-west lamp, {R,Y,G} one-hot.
REQ-010 walk  output  1  pedestrian walk lamp.
REQ-011 state  output  3  current FSM state code, for debug and verification.

Function
REQ-012 SHALL use states and codes: NS_G=0, NS_Y=1, RED_A=2, EW_G=3, EW_Y=4, RED_B=5, WALK=6; code 7 SHALL go to RED_B on the next edge.
REQ-013 SHALL drive outputs as a pure decode of the state register (Moore), with no combinational input-to-output path.
REQ-014 SHALL decode lamps as follows:
- NS_G: ns=001, ew=100.
- NS_Y: ns=010, ew=100.
- EW_G: ns=100, ew=001.
- EW_Y: ns=100, ew=010.
- RED_A, RED_B, WALK: ns=100, ew=100.
REQ-015 SHALL assert walk=1 only in WALK.
REQ-016 SHALL never drive green or yellow on both directions simultaneously, in any state.
REQ-017 SHALL define phase expiry as tick=1 and timer==DUR-1, where DUR is the current state's duration.
REQ-018 SHALL, on expiry, move to the next state and clear the timer to 0 at the same edge.
REQ-019 SHALL otherwise increment the timer by 1 on tick and hold it on !tick.
REQ-020 SHALL give each state a length of exactly DUR ticks; with tick held at 1 this is exactly DUR cycles.
REQ-021 SHALL follow the normal sequence NS_G -> NS_Y -> RED_A -> EW_G -> EW_Y -> RED_B.
REQ-022 SHALL, on RED_B expiry, go to WALK if ped_pending=1, otherwise to NS_G.
REQ-023 SHALL, on WALK expiry, go to NS_G.
REQ-024 SHALL set ped_pending on any cycle with ped_req=1 and clear it on the edge entering WALK; when set and clear coincide, set SHALL win.
REQ-025 SHALL handle emerg=1 per state:
- NS_G goes to NS_Y next edge, timer cleared.
- EW_G goes to EW_Y next edge, timer cleared.
- WALK goes to RED_B next edge, timer cleared.
- Yellows run to normal expiry.
- RED_A and RED_B hold with the timer held at 0.
REQ-026 SHALL, on emerg release, time the held all-red state for its full ALLRED_TICKS from 0.
REQ-027 SHALL NOT clear ped_pending on emerg.
REQ-028 SHALL make the timer saturation-free, since expiry always precedes wrap under REQ-002.

Reset
REQ-029 SHALL, when rst=1 at posedge, set state=RED_B, timer=0, ped_pending=0; outputs then read ns=100, ew=100, walk=0.
REQ-030 SHALL give rst priority over tick, emerg and ped_req, including mid-phase, and SHALL discard any pending request.
REQ-031 SHALL place no reset-dependent logic outside the clocked process, and SHALL use no initial-value reliance.

Structure
REQ-032 SHALL take state codes, the lamp encodings (RED=100, YELLOW=010, GREEN=001) and state width from shared package traffic_pkg.
REQ-033 SHALL implement the timer as sub-module phase_timer, with ports clk, rst, tick, clear, dur, expire and a TIMER_WIDTH parameter.
REQ-034 SHALL implement the state and pending registers with the codebase's DFF (REGISTER_WIDTH=3 and 1), with the reset mux placed in front of D.

Verification
REQ-035 SHALL run all scenarios with params GREEN=4, YELLOW=2, ALLRED=1, WALK=3, TIMER_WIDTH=8 and tick=1 every cycle unless stated.
REQ-036 Reset then free run, no requests -> state 5,0,0,0,0,1,1,2,3,3,3,3,4,4,5,0,... with a 14-cycle period; ns/ew never both non-red.
REQ-037 ped_req pulse during EW_G -> after RED_B comes WALK for 3 cycles with walk=1, then NS_G; ped_pending=0 after WALK entry.
REQ-038 emerg raised in cycle 2 of NS_G -> NS_Y next cycle, 2 cycles of yellow, RED_A held while emerg=1; release -> 1 cycle RED_A, then EW_G.
REQ-039 tick=1 every 3rd cycle -> NS_G lasts 12 cycles; the timer holds between ticks.
REQ-040 rst asserted in mid EW_Y with ped_pending=1 -> next cycle state=5, timer=0, no WALK after RED_B; also force state=7 -> RED_B next edge.
